alu_arbiter: RTL and testbench

//   Shares one combinational 32-bit ALU (inA/inB/operation -> result/zero) between two

---
 rtl/alu_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters,
// holding operands for EXEC_CYCLES and returning a registered result over valid/ready.
module alu_arbiter #(
    parameter int WIDTH       = 32,
    parameter int OPW         = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_inA,
    input  logic [WIDTH-1:0] req0_inB,
    input  logic [OPW-1:0]   req0_operation,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_inA,
    input  logic [WIDTH-1:0] req1_inB,
    input  logic [OPW-1:0]   req1_operation,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_inA,
    output logic [WIDTH-1:0] alu_inB,
    output logic [OPW-1:0]   alu_operation,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);

    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          last_grant;
    logic          owner;
    logic [CW-1:0] cnt;
    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          rsp_done;

    // last_grant==1 means requester 1 was served last, so requester 0 wins a tie
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
    end

    always_comb begin
        accept   = (state == IDLE) & (grant0 | grant1);
        rsp_done = (state == RESP) & (owner ? rsp1_ready : rsp0_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 | grant1) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp0_valid = ~owner;
                rsp1_valid = owner;
                if (rsp_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands stay on the ALU after the transaction so its inputs do not toggle while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_inA       <= '0;
            alu_inB       <= '0;
            alu_operation <= '0;
            owner         <= 1'b0;
            last_grant    <= 1'b1;
            cnt           <= '0;
            rsp_result    <= '0;
            rsp_zero      <= 1'b0;
        end else begin
            if (accept) begin
                owner         <= grant1;
                alu_inA       <= grant1 ? req1_inA : req0_inA;
                alu_inB       <= grant1 ? req1_inB : req0_inB;
                alu_operation <= grant1 ? req1_operation : req0_operation;
                cnt           <= CNT_INIT;
            end
            if (state == EXEC) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                end
            end
            if (rsp_done) begin
                last_grant <= owner;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: instance A with EXEC_CYCLES=1, instance B with EXEC_CYCLES=3,
// each driving a behavioural ALU; a transaction-level arbitration model checks random traffic.
module tb_alu_arbiter;
    localparam int W   = 32;
    localparam int OPW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    logic           req0_valid_a, req0_ready_a, rsp0_valid_a, rsp0_ready_a;
    logic           req1_valid_a, req1_ready_a, rsp1_valid_a, rsp1_ready_a;
    logic [W-1:0]   req0_inA_a, req0_inB_a, req1_inA_a, req1_inB_a;
    logic [OPW-1:0] req0_op_a, req1_op_a, alu_op_a;
    logic [W-1:0]   rsp_result_a, alu_inA_a, alu_inB_a, alu_result_a;
    logic           rsp_zero_a, alu_zero_a, busy_a;

    logic           req0_valid_b, req0_ready_b, rsp0_valid_b, rsp0_ready_b;
    logic           req1_valid_b, req1_ready_b, rsp1_valid_b, rsp1_ready_b;
    logic [W-1:0]   req0_inA_b, req0_inB_b, req1_inA_b, req1_inB_b;
    logic [OPW-1:0] req0_op_b, req1_op_b, alu_op_b;
    logic [W-1:0]   rsp_result_b, alu_inA_b, alu_inB_b, alu_result_b;
    logic           rsp_zero_b, alu_zero_b, busy_b;

    function automatic logic [W-1:0] alu_fn(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return W'(($signed(a) < $signed(b)) ? 1 : 0);
            4'b1100: return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result_a = alu_fn(alu_op_a, alu_inA_a, alu_inB_a);
    assign alu_zero_a   = (alu_result_a == '0);
    assign alu_result_b = alu_fn(alu_op_b, alu_inA_b, alu_inB_b);
    assign alu_zero_b   = (alu_result_b == '0);

    alu_arbiter #(.WIDTH(W), .OPW(OPW), .EXEC_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid_a), .req0_ready(req0_ready_a), .req0_inA(req0_inA_a),
        .req0_inB(req0_inB_a), .req0_operation(req0_op_a),
        .rsp0_valid(rsp0_valid_a), .rsp0_ready(rsp0_ready_a),
        .req1_valid(req1_valid_a), .req1_ready(req1_ready_a), .req1_inA(req1_inA_a),
        .req1_inB(req1_inB_a), .req1_operation(req1_op_a),
        .rsp1_valid(rsp1_valid_a), .rsp1_ready(rsp1_ready_a),
        .rsp_result(rsp_result_a), .rsp_zero(rsp_zero_a),
        .alu_inA(alu_inA_a), .alu_inB(alu_inB_a), .alu_operation(alu_op_a),
        .alu_result(alu_result_a), .alu_zero(alu_zero_a), .busy(busy_a)
    );

    alu_arbiter #(.WIDTH(W), .OPW(OPW), .EXEC_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid_b), .req0_ready(req0_ready_b), .req0_inA(req0_inA_b),
        .req0_inB(req0_inB_b), .req0_operation(req0_op_b),
        .rsp0_valid(rsp0_valid_b), .rsp0_ready(rsp0_ready_b),
        .req1_valid(req1_valid_b), .req1_ready(req1_ready_b), .req1_inA(req1_inA_b),
        .req1_inB(req1_inB_b), .req1_operation(req1_op_b),
        .rsp1_valid(rsp1_valid_b), .rsp1_ready(rsp1_ready_b),
        .rsp_result(rsp_result_b), .rsp_zero(rsp_zero_b),
        .alu_inA(alu_inA_b), .alu_inB(alu_inB_b), .alu_operation(alu_op_b),
        .alu_result(alu_result_b), .alu_zero(alu_zero_b), .busy(busy_b)
    );

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        {req0_valid_a, req1_valid_a, rsp0_ready_a, rsp1_ready_a} = '0;
        {req0_inA_a, req0_inB_a, req1_inA_a, req1_inB_a, req0_op_a, req1_op_a} = '0;
        {req0_valid_b, req1_valid_b, rsp0_ready_b, rsp1_ready_b} = '0;
        {req0_inA_b, req0_inB_b, req1_inA_b, req1_inB_b, req0_op_b, req1_op_b} = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({req0_ready_a, req1_ready_a, rsp0_valid_a, rsp1_valid_a, busy_a} !== 5'b0) begin
                $display("FAIL reset_ctrl_a cyc=%0d got=%b want=00000", i,
                         {req0_ready_a, req1_ready_a, rsp0_valid_a, rsp1_valid_a, busy_a});
            end else passed++;
            total++;
            if ({alu_inA_a, alu_inB_a, alu_op_a, rsp_result_a, rsp_zero_a} !== '0) begin
                $display("FAIL reset_data_a cyc=%0d inA=%h inB=%h op=%h res=%h z=%b want all 0", i,
                         alu_inA_a, alu_inB_a, alu_op_a, rsp_result_a, rsp_zero_a);
            end else passed++;
            total++;
            if ({req0_ready_b, req1_ready_b, rsp0_valid_b, rsp1_valid_b, busy_b} !== 5'b0) begin
                $display("FAIL reset_ctrl_b cyc=%0d got=%b want=00000", i,
                         {req0_ready_b, req1_ready_b, rsp0_valid_b, rsp1_valid_b, busy_b});
            end else passed++;
            total++;
            if ({alu_inA_b, alu_inB_b, alu_op_b, rsp_result_b, rsp_zero_b} !== '0) begin
                $display("FAIL reset_data_b cyc=%0d inA=%h inB=%h op=%h res=%h z=%b want all 0", i,
                         alu_inA_b, alu_inB_b, alu_op_b, rsp_result_b, rsp_zero_b);
            end else passed++;
        end
    endtask

    task automatic test_add;
        do_reset();
        @(negedge clk);
        req0_valid_a = 1'b1; req0_inA_a = 32'd5; req0_inB_a = 32'd3; req0_op_a = 4'b0010;
        rsp0_ready_a = 1'b1; rsp1_ready_a = 1'b1;
        #1;
        total++;
        if ({req0_ready_a, req1_ready_a} !== 2'b10) begin
            $display("FAIL add_ready got=%b want=10", {req0_ready_a, req1_ready_a});
        end else passed++;
        @(negedge clk);
        req0_valid_a = 1'b0;
        total++;
        if ({rsp0_valid_a, rsp1_valid_a, busy_a, alu_inA_a, alu_inB_a, alu_op_a} !==
            {3'b001, 32'd5, 32'd3, 4'b0010}) begin
            $display("FAIL add_exec vld0=%b vld1=%b busy=%b inA=%h inB=%h op=%h want 0,0,1,5,3,2",
                     rsp0_valid_a, rsp1_valid_a, busy_a, alu_inA_a, alu_inB_a, alu_op_a);
        end else passed++;
        @(negedge clk);
        total++;
        if ({rsp0_valid_a, rsp1_valid_a, rsp_result_a, rsp_zero_a} !== {2'b10, 32'h8, 1'b0}) begin
            $display("FAIL add_resp vld0=%b vld1=%b res=%h z=%b want 1,0,00000008,0",
                     rsp0_valid_a, rsp1_valid_a, rsp_result_a, rsp_zero_a);
        end else passed++;
        @(negedge clk);
        total++;
        if ({rsp0_valid_a, rsp1_valid_a, busy_a, alu_inA_a, alu_inB_a, alu_op_a} !==
            {3'b000, 32'd5, 32'd3, 4'b0010}) begin
            $display("FAIL add_done vld0=%b vld1=%b busy=%b inA=%h inB=%h op=%h want 0,0,0,5,3,2",
                     rsp0_valid_a, rsp1_valid_a, busy_a, alu_inA_a, alu_inB_a, alu_op_a);
        end else passed++;
    endtask

    task automatic test_stall;
        do_reset();
        @(negedge clk);
        req1_valid_a = 1'b1; req1_inA_a = 32'd7; req1_inB_a = 32'd7; req1_op_a = 4'b0110;
        rsp1_ready_a = 1'b0;
        #1;
        total++;
        if ({req0_ready_a, req1_ready_a} !== 2'b01) begin
            $display("FAIL stall_accept got=%b want=01", {req0_ready_a, req1_ready_a});
        end else passed++;
        @(negedge clk);
        req1_valid_a = 1'b0;
        req0_valid_a = 1'b1; req0_inA_a = 32'd1; req0_inB_a = 32'd2; req0_op_a = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({rsp0_valid_a, rsp1_valid_a, req0_ready_a, rsp_result_a, rsp_zero_a} !==
                {3'b010, 32'h0, 1'b1}) begin
                $display("FAIL stall_hold cyc=%0d vld0=%b vld1=%b rdy0=%b res=%h z=%b want 0,1,0,0,1",
                         i, rsp0_valid_a, rsp1_valid_a, req0_ready_a, rsp_result_a, rsp_zero_a);
            end else passed++;
        end
        rsp1_ready_a = 1'b1;
        @(negedge clk);
        total++;
        if ({req0_ready_a, rsp1_valid_a} !== 2'b10) begin
            $display("FAIL stall_release rdy0=%b vld1=%b want 1,0", req0_ready_a, rsp1_valid_a);
        end else passed++;
    endtask

    task automatic test_fairness;
        logic [W-1:0]   ea [2][6];
        logic [W-1:0]   eb [2][6];
        logic [OPW-1:0] eo [2][6];
        logic [OPW-1:0] ops [6];
        logic [W-1:0]   exp_res;
        int acc [2];
        int done;
        int order_k;
        int cur;
        ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
        for (int r = 0; r < 2; r++) begin
            acc[r] = 0;
            for (int k = 0; k < 6; k++) begin
                ea[r][k] = $urandom;
                eb[r][k] = $urandom;
                eo[r][k] = ops[$urandom_range(0, 5)];
            end
        end
        done = 0; order_k = 0; cur = 0; exp_res = '0;
        do_reset();
        rsp0_ready_a = 1'b1; rsp1_ready_a = 1'b1;
        for (int cyc = 0; cyc < 200 && done < 12; cyc++) begin
            @(negedge clk);
            req0_valid_a = (acc[0] < 6);
            req1_valid_a = (acc[1] < 6);
            if (acc[0] < 6) begin
                req0_inA_a = ea[0][acc[0]]; req0_inB_a = eb[0][acc[0]]; req0_op_a = eo[0][acc[0]];
            end
            if (acc[1] < 6) begin
                req1_inA_a = ea[1][acc[1]]; req1_inB_a = eb[1][acc[1]]; req1_op_a = eo[1][acc[1]];
            end
            #1;
            if (rsp0_valid_a | rsp1_valid_a) begin
                total++;
                if ({rsp0_valid_a, rsp1_valid_a, rsp_result_a, rsp_zero_a} !==
                    {~cur[0], cur[0], exp_res, (exp_res == '0)}) begin
                    $display("FAIL fair_result n=%0d vld=%b%b res=%h z=%b want owner=%0d res=%h", done,
                             rsp0_valid_a, rsp1_valid_a, rsp_result_a, rsp_zero_a, cur, exp_res);
                end else passed++;
                done++;
            end
            if (req0_ready_a | req1_ready_a) begin
                total++;
                if ({req0_ready_a, req1_ready_a} !== ((order_k % 2 == 0) ? 2'b10 : 2'b01)) begin
                    $display("FAIL fair_order k=%0d got=%b want owner %0d", order_k,
                             {req0_ready_a, req1_ready_a}, order_k % 2);
                end else passed++;
                cur = req1_ready_a ? 1 : 0;
                exp_res = alu_fn(eo[cur][acc[cur]], ea[cur][acc[cur]], eb[cur][acc[cur]]);
                acc[cur]++;
                order_k++;
            end
        end
        total++;
        if (done != 12 || acc[0] != 6 || acc[1] != 6) begin
            $display("FAIL fair_complete responses=%0d acc0=%0d acc1=%0d want 12,6,6", done, acc[0], acc[1]);
        end else passed++;
        req0_valid_a = 1'b0; req1_valid_a = 1'b0;
    endtask

    task automatic test_exec3;
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = $urandom; b = $urandom;
        do_reset();
        @(negedge clk);
        req0_valid_b = 1'b1; req0_inA_b = a; req0_inB_b = b; req0_op_b = 4'b0010;
        rsp0_ready_b = 1'b1;
        #1;
        total++;
        if ({req0_ready_b, req1_ready_b} !== 2'b10) begin
            $display("FAIL exec3_accept got=%b want=10", {req0_ready_b, req1_ready_b});
        end else passed++;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            req0_valid_b = 1'b0;
            req0_inA_b = $urandom; req0_inB_b = $urandom;
            total++;
            if ({alu_inA_b, alu_inB_b, alu_op_b, rsp0_valid_b, busy_b} !== {a, b, 4'b0010, 2'b01}) begin
                $display("FAIL exec3_hold cyc=%0d inA=%h inB=%h op=%h vld=%b busy=%b want %h %h 2 0 1",
                         i, alu_inA_b, alu_inB_b, alu_op_b, rsp0_valid_b, busy_b, a, b);
            end else passed++;
        end
        @(negedge clk);
        total++;
        if ({rsp0_valid_b, rsp_result_b} !== {1'b1, a + b}) begin
            $display("FAIL exec3_resp vld=%b res=%h want 1 %h", rsp0_valid_b, rsp_result_b, a + b);
        end else passed++;
    endtask

    task automatic test_reset_mid_exec;
        do_reset();
        @(negedge clk);
        req1_valid_b = 1'b1; req1_inA_b = 32'd9; req1_inB_b = 32'd4; req1_op_b = 4'b0110;
        rsp0_ready_b = 1'b1; rsp1_ready_b = 1'b1;
        #1;
        total++;
        if ({req0_ready_b, req1_ready_b} !== 2'b01) begin
            $display("FAIL midrst_accept got=%b want=01", {req0_ready_b, req1_ready_b});
        end else passed++;
        @(negedge clk);
        req1_valid_b = 1'b0;
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        total++;
        if ({busy_b, alu_inA_b, alu_inB_b, alu_op_b} !== '0) begin
            $display("FAIL midrst_clear busy=%b inA=%h inB=%h op=%h want all 0",
                     busy_b, alu_inA_b, alu_inB_b, alu_op_b);
        end else passed++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if ({rsp0_valid_b, rsp1_valid_b, busy_b} !== 3'b000) begin
                $display("FAIL midrst_quiet cyc=%0d got=%b want=000", i,
                         {rsp0_valid_b, rsp1_valid_b, busy_b});
            end else passed++;
        end
        req0_valid_b = 1'b1; req1_valid_b = 1'b1;
        #1;
        total++;
        if ({req0_ready_b, req1_ready_b} !== 2'b10) begin
            $display("FAIL midrst_next got=%b want=10", {req0_ready_b, req1_ready_b});
        end else passed++;
        @(negedge clk);
        req0_valid_b = 1'b0; req1_valid_b = 1'b0;
    endtask

    task automatic test_random;
        logic           pend [2];
        logic           v [2];
        logic           rr [2];
        logic [W-1:0]   pa [2];
        logic [W-1:0]   pb [2];
        logic [OPW-1:0] po [2];
        logic [OPW-1:0] ops [6];
        logic [W-1:0]   exp_res;
        logic [1:0]     exp_ready;
        logic [1:0]     exp_rv;
        logic           outst;
        int             owner, last, age;
        int             served [2];
        ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; served[r] = 0; pa[r] = '0; pb[r] = '0; po[r] = '0;
        end
        outst = 1'b0; owner = 0; last = 1; age = 0; exp_res = '0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1'b1;
                    pa[r] = $urandom;
                    pb[r] = ($urandom_range(0, 3) == 0) ? pa[r] : $urandom;
                    po[r] = ops[$urandom_range(0, 5)];
                end
                v[r]  = pend[r] && ($urandom_range(0, 3) != 0);
                rr[r] = ($urandom_range(0, 2) != 0);
            end
            req0_valid_a = v[0]; req0_inA_a = pa[0]; req0_inB_a = pb[0]; req0_op_a = po[0];
            req1_valid_a = v[1]; req1_inA_a = pa[1]; req1_inB_a = pb[1]; req1_op_a = po[1];
            rsp0_ready_a = rr[0]; rsp1_ready_a = rr[1];
            #1;
            exp_ready = outst ? 2'b00 : {v[0] & (~v[1] | (last == 1)), v[1] & (~v[0] | (last == 0))};
            total++;
            if ({req0_ready_a, req1_ready_a} !== exp_ready) begin
                $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, {req0_ready_a, req1_ready_a},
                         exp_ready);
            end else passed++;
            if (outst) begin
                age++;
                exp_rv = (age >= 2) ? ((owner == 1) ? 2'b01 : 2'b10) : 2'b00;
                total++;
                if ({rsp0_valid_a, rsp1_valid_a, busy_a} !== {exp_rv, 1'b1}) begin
                    $display("FAIL rand_busy cyc=%0d got=%b want=%b1", cyc,
                             {rsp0_valid_a, rsp1_valid_a, busy_a}, exp_rv);
                end else passed++;
                if (age >= 2 && rr[owner]) begin
                    total++;
                    if ({rsp_result_a, rsp_zero_a} !== {exp_res, (exp_res == '0)}) begin
                        $display("FAIL rand_result cyc=%0d res=%h z=%b want %h", cyc, rsp_result_a,
                                 rsp_zero_a, exp_res);
                    end else passed++;
                    outst = 1'b0;
                    last = owner;
                    served[owner]++;
                end
            end else if (exp_ready != 2'b00) begin
                owner = exp_ready[0] ? 1 : 0;
                exp_res = alu_fn(po[owner], pa[owner], pb[owner]);
                pend[owner] = 1'b0;
                outst = 1'b1;
                age = 0;
            end else begin
                total++;
                if ({rsp0_valid_a, rsp1_valid_a, busy_a} !== 3'b000) begin
                    $display("FAIL rand_idle cyc=%0d got=%b want=000", cyc,
                             {rsp0_valid_a, rsp1_valid_a, busy_a});
                end else passed++;
            end
        end
        total++;
        if (served[0] == 0 || served[1] == 0) begin
            $display("FAIL rand_starve served0=%0d served1=%0d want both >0", served[0], served[1]);
        end else passed++;
        req0_valid_a = 1'b0; req1_valid_a = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_stall();
        test_fairness();
        test_exec3();
        test_reset_mid_exec();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
